// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes and FSM states.
package dmem_responder_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WACK  = 3'd1,
      RWAIT = 3'd2,
      RACK  = 3'd3,
      EACK  = 3'd4
   } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data array built from four byte lanes; synchronous read, per-lane write.
module dmem_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          i_clk,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_q;

      // Read-before-write: a same-edge read returns the old byte.
      always_ff @(posedge i_clk) begin
         if (i_we[l]) mem[i_addr] <= i_wdata[8*l +: 8];
         rd_q <= mem[i_addr];
      end

      assign o_rdata[8*l +: 8] = rd_q;
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: decodes size/alignment/range faults, writes stores at
// acceptance, and returns aligned, extended load data two cycles after acceptance.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        i_CLK,
   input  logic        i_RSTn,
   input  logic [31:0] i_MEM_ADDR,
   input  logic [31:0] i_MEM_WDATA,
   input  logic        i_MEM_WE,
   input  logic        i_MEM_RE,
   input  logic [1:0]  i_HB,
   input  logic        i_ULOAD,
   output logic [31:0] o_MEM_RDATA,
   output logic        o_ACK,
   output logic        o_FAULT
);

   localparam int          AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   state_e      state_q, state_d;
   logic        ack_q, ack_d;
   logic        fault_q, fault_d;
   logic [31:0] rdata_q, rdata_d;

   logic        req, in_range, fault;
   logic [31:0] off;
   logic [3:0]  be, ram_we;
   logic [31:0] wdata_rep, ram_rdata, load_ext;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign req      = i_MEM_RE | i_MEM_WE;
   assign off      = i_MEM_ADDR - BASE_ADDR;
   assign in_range = (i_MEM_ADDR >= BASE_ADDR) && ({1'b0, off} < SPAN);
   assign fault    = (i_MEM_RE & i_MEM_WE) || (i_HB == 2'b11) ||
                     (i_HB == SZ_HALF && i_MEM_ADDR[0]) ||
                     (i_HB == SZ_WORD && i_MEM_ADDR[1:0] != 2'b00) || !in_range;

   always_comb begin
      be        = 4'b1111;
      wdata_rep = i_MEM_WDATA;
      case (i_HB)
         SZ_BYTE: begin
            be        = 4'b0001 << i_MEM_ADDR[1:0];
            wdata_rep = {4{i_MEM_WDATA[7:0]}};
         end
         SZ_HALF: begin
            be        = 4'b0011 << i_MEM_ADDR[1:0];
            wdata_rep = {2{i_MEM_WDATA[15:0]}};
         end
         default: ;
      endcase
   end

   // The request is held stable through RWAIT, so the address still selects the lane.
   always_comb begin
      byte_sel = ram_rdata[7:0];
      case (i_MEM_ADDR[1:0])
         2'd1:    byte_sel = ram_rdata[15:8];
         2'd2:    byte_sel = ram_rdata[23:16];
         2'd3:    byte_sel = ram_rdata[31:24];
         default: ;
      endcase
      half_sel = i_MEM_ADDR[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      case (i_HB)
         SZ_BYTE: load_ext = {{24{~i_ULOAD & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_ext = {{16{~i_ULOAD & half_sel[15]}}, half_sel};
         default: load_ext = ram_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      fault_d = 1'b0;
      rdata_d = rdata_q;
      ram_we  = 4'b0000;
      case (state_q)
         IDLE: if (req) begin
            if (fault) begin
               state_d = EACK;
               ack_d   = 1'b1;
               fault_d = 1'b1;
               rdata_d = 32'h0;
            end else if (i_MEM_WE) begin
               state_d = WACK;
               ack_d   = 1'b1;
               ram_we  = be & {4{i_RSTn}};
            end else begin
               state_d = RWAIT;
            end
         end
         RWAIT: begin
            state_d = RACK;
            ack_d   = 1'b1;
            rdata_d = load_ext;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         fault_q <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .i_clk   (i_CLK),
      .i_we    (ram_we),
      .i_addr  (off[AW+1:2]),
      .i_wdata (wdata_rep),
      .o_rdata (ram_rdata)
   );

   assign o_ACK       = ack_q;
   assign o_FAULT     = fault_q;
   assign o_MEM_RDATA = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, multi-cycle corner sequences, and
// randomized traffic against a byte-addressed reference memory.
module tb_dmem_responder;

   logic        i_CLK = 1'b0;
   logic        i_RSTn = 1'b0;
   logic [31:0] i_MEM_ADDR = '0;
   logic [31:0] i_MEM_WDATA = '0;
   logic        i_MEM_WE = 1'b0;
   logic        i_MEM_RE = 1'b0;
   logic [1:0]  i_HB = 2'b00;
   logic        i_ULOAD = 1'b0;
   logic [31:0] o_MEM_RDATA;
   logic        o_ACK;
   logic        o_FAULT;

   int total = 0;
   int bad   = 0;

   always #5 i_CLK = ~i_CLK;

   dmem_responder dut (
      .i_CLK       (i_CLK),
      .i_RSTn      (i_RSTn),
      .i_MEM_ADDR  (i_MEM_ADDR),
      .i_MEM_WDATA (i_MEM_WDATA),
      .i_MEM_WE    (i_MEM_WE),
      .i_MEM_RE    (i_MEM_RE),
      .i_HB        (i_HB),
      .i_ULOAD     (i_ULOAD),
      .o_MEM_RDATA (o_MEM_RDATA),
      .o_ACK       (o_ACK),
      .o_FAULT     (o_FAULT)
   );

   typedef struct {
      logic        we, re;
      logic [1:0]  hb;
      logic        ul;
      logic [31:0] a, wd;
      logic        ef;
      logic [31:0] erd;
      logic        crd;
      string       nm;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic re, input logic [1:0] hb, input logic ul,
                        input logic [31:0] a, input logic [31:0] wd);
      i_MEM_WE = we; i_MEM_RE = re; i_HB = hb; i_ULOAD = ul;
      i_MEM_ADDR = a; i_MEM_WDATA = wd;
   endtask

   task automatic xact(input logic we, input logic re, input logic [1:0] hb, input logic ul,
                       input logic [31:0] a, input logic [31:0] wd, input logic ef,
                       input logic [31:0] erd, input logic crd, input string nm);
      int   n;
      logic got;
      @(negedge i_CLK);
      drive(we, re, hb, ul, a, wd);
      n = 0; got = 1'b0;
      while (!got && n < 6) begin
         @(posedge i_CLK); #1;
         n++;
         got = o_ACK;
      end
      chk({nm, " latency"}, got ? 32'(n) : 32'd99, (ef || we) ? 32'd1 : 32'd2);
      chk({nm, " fault"}, {31'b0, o_FAULT}, {31'b0, ef});
      if (crd || ef) chk({nm, " rdata"}, o_MEM_RDATA, ef ? 32'h0 : erd);
      @(negedge i_CLK);
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   function automatic vec_t mk(input logic we, input logic re, input logic [1:0] hb,
                               input logic ul, input logic [31:0] a, input logic [31:0] wd,
                               input logic ef, input logic [31:0] erd, input string nm);
      vec_t v;
      v.we = we; v.re = re; v.hb = hb; v.ul = ul; v.a = a; v.wd = wd;
      v.ef = ef; v.erd = erd; v.crd = re & ~we; v.nm = nm;
      return v;
   endfunction

   logic [7:0] mdl [256];

   initial begin
      vec_t tv[$];

      #3;
      chk("reset ack", {31'b0, o_ACK}, 32'h0);
      chk("reset fault", {31'b0, o_FAULT}, 32'h0);
      chk("reset rdata", o_MEM_RDATA, 32'h0);
      repeat (2) @(negedge i_CLK);
      i_RSTn = 1'b1;

      for (int w = 0; w < 128; w++)
         xact(1, 0, 2'b10, 0, 32'(w * 4), 32'h0, 0, 32'h0, 0, "init");

      tv.push_back(mk(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        "st w 10"));
      tv.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, "ld w 10"));
      tv.push_back(mk(0, 1, 2'b00, 0, 32'h11, 32'h0,        0, 32'hFFFFFFBE, "ld b 11 s"));
      tv.push_back(mk(0, 1, 2'b00, 1, 32'h11, 32'h0,        0, 32'h000000BE, "ld b 11 u"));
      tv.push_back(mk(1, 0, 2'b01, 0, 32'h12, 32'h00001234, 0, 32'h0,        "st h 12"));
      tv.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h0,        0, 32'h1234BEEF, "ld w 10 b"));
      tv.push_back(mk(0, 1, 2'b10, 0, 32'h11, 32'h0,        1, 32'h0,        "mis w 11"));
      tv.push_back(mk(0, 1, 2'b01, 0, 32'h13, 32'h0,        1, 32'h0,        "mis h 13"));
      tv.push_back(mk(1, 1, 2'b10, 0, 32'h10, 32'h0,        1, 32'h0,        "re+we"));
      tv.push_back(mk(1, 0, 2'b11, 0, 32'h10, 32'h0,        1, 32'h0,        "hb 11"));
      tv.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h0,        0, 32'h1234BEEF, "unchanged"));
      tv.push_back(mk(0, 1, 2'b01, 0, 32'h12, 32'h0,        0, 32'h00001234, "ld h 12"));
      tv.push_back(mk(0, 1, 2'b01, 0, 32'h10, 32'h0,        0, 32'hFFFFBEEF, "ld h 10 s"));
      tv.push_back(mk(0, 1, 2'b01, 1, 32'h10, 32'h0,        0, 32'h0000BEEF, "ld h 10 u"));
      tv.push_back(mk(1, 0, 2'b00, 0, 32'h13, 32'h00000080, 0, 32'h0,        "st b 13"));
      tv.push_back(mk(0, 1, 2'b00, 0, 32'h13, 32'h0,        0, 32'hFFFFFF80, "ld b 13"));
      tv.push_back(mk(0, 1, 2'b10, 0, 32'h10, 32'h0,        0, 32'h8034BEEF, "ld w 10 c"));
      tv.push_back(mk(1, 0, 2'b10, 0, 32'hFFC, 32'hCAFEF00D, 0, 32'h0,       "st top"));
      tv.push_back(mk(0, 1, 2'b10, 0, 32'hFFC, 32'h0,       0, 32'hCAFEF00D, "ld top"));
      tv.push_back(mk(0, 1, 2'b10, 0, 32'h1000, 32'h0,      1, 32'h0,        "ld oor"));
      tv.push_back(mk(1, 0, 2'b10, 0, 32'h1000, 32'hAAAAAAAA, 1, 32'h0,      "st oor"));
      tv.push_back(mk(0, 1, 2'b10, 0, 32'h0,  32'h0,        0, 32'h0,        "no alias"));
      foreach (tv[i])
         xact(tv[i].we, tv[i].re, tv[i].hb, tv[i].ul, tv[i].a, tv[i].wd,
              tv[i].ef, tv[i].erd, tv[i].crd, tv[i].nm);

      // Requests held high across the ack are re-accepted the following cycle.
      @(negedge i_CLK);
      drive(1, 0, 2'b10, 0, 32'h20, 32'h11111111);
      for (int e = 0; e < 4; e++) begin
         @(posedge i_CLK); #1;
         chk("b2b st ack", {31'b0, o_ACK}, (e % 2 == 0) ? 32'd1 : 32'd0);
      end
      @(negedge i_CLK);
      drive(0, 1, 2'b10, 0, 32'h20, 32'h0);
      for (int e = 0; e < 6; e++) begin
         @(posedge i_CLK); #1;
         chk("b2b ld ack", {31'b0, o_ACK}, (e == 1 || e == 4) ? 32'd1 : 32'd0);
         if (e == 1 || e == 4) chk("b2b ld rdata", o_MEM_RDATA, 32'h11111111);
      end
      @(negedge i_CLK);
      drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
      repeat (2) @(posedge i_CLK);
      #1;
      chk("hold ack", {31'b0, o_ACK}, 32'h0);
      chk("hold rdata", o_MEM_RDATA, 32'h11111111);

      // Reset while a load sits in RWAIT.
      @(negedge i_CLK);
      drive(0, 1, 2'b10, 0, 32'h20, 32'h0);
      @(posedge i_CLK); #1;
      chk("rwait ack", {31'b0, o_ACK}, 32'h0);
      #2 i_RSTn = 1'b0;
      #1;
      chk("rst rdata", o_MEM_RDATA, 32'h0);
      chk("rst ack", {31'b0, o_ACK}, 32'h0);
      chk("rst fault", {31'b0, o_FAULT}, 32'h0);
      @(posedge i_CLK); #1;
      chk("rst no ack", {31'b0, o_ACK}, 32'h0);
      @(negedge i_CLK);
      drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
      i_RSTn = 1'b1;
      xact(0, 1, 2'b10, 0, 32'h20, 32'h0, 0, 32'h11111111, 1, "after rst");

      // Reset during WACK keeps the store already written at acceptance.
      @(negedge i_CLK);
      drive(1, 0, 2'b10, 0, 32'h24, 32'h5A5A5A5A);
      @(posedge i_CLK); #1;
      chk("wack ack", {31'b0, o_ACK}, 32'h1);
      i_RSTn = 1'b0;
      #1;
      chk("wack rst ack", {31'b0, o_ACK}, 32'h0);
      @(negedge i_CLK);
      drive(0, 0, 2'b00, 0, 32'h0, 32'h0);
      i_RSTn = 1'b1;
      xact(0, 1, 2'b10, 0, 32'h24, 32'h0, 0, 32'h5A5A5A5A, 1, "st kept");

      // Random traffic in 0x100..0x1FF, plus out-of-range addresses.
      for (int k = 0; k < 256; k++) mdl[k] = 8'h00;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, wd, v, erd;
         logic [1:0]  hb;
         logic        we, re, ul, ef;
         int          r, sz, o;
         r  = int'($urandom_range(0, 15));
         hb = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
         sz = (hb == 2'b00) ? 1 : (hb == 2'b01) ? 2 : 4;
         a  = 32'h100 + $urandom_range(0, 255);
         if ($urandom_range(0, 3) != 0 && hb != 2'b11) a = a & ~32'(sz - 1);
         if ($urandom_range(0, 9) == 0)
            a = ($urandom_range(0, 1) == 1) ? 32'h1000 + $urandom_range(0, 63)
                                             : 32'hFFFF_FF00 + $urandom_range(0, 255);
         r  = int'($urandom_range(0, 15));
         we = (r <= 7);
         re = (r == 0) || (r > 7);
         ul = 1'($urandom_range(0, 1));
         wd = $urandom;
         ef = (we && re) || hb == 2'b11 || (hb == 2'b01 && a[0]) ||
              (hb == 2'b10 && a[1:0] != 2'b00) || a >= 32'h1000;
         erd = 32'h0;
         if (!ef) begin
            o = int'(a) - 32'h100;
            if (we) begin
               for (int k = 0; k < sz; k++) mdl[o + k] = wd[8*k +: 8];
            end else begin
               v = 32'h0;
               for (int k = 0; k < sz; k++) v = v | (32'(mdl[o + k]) << (8 * k));
               if (!ul && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
               if (!ul && sz == 2 && v[15]) v = v | 32'hFFFF0000;
               erd = v;
            end
         end
         xact(we, re, hb, ul, a, wd, ef, erd, re & ~we, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, the number of 32-bit words in the internal data array (power of two).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, the byte address of word 0.
REQ-003 i_CLK  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 i_RSTn  input  1  is the asynchronous, active-low reset.
REQ-005 i_MEM_ADDR  input  32  is the byte address of the request.
REQ-006 i_MEM_WDATA  input  32  is the store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 i_MEM_WE  input  1  is the store request.
REQ-008 i_MEM_RE  input  1  is the load request.
REQ-009 i_HB  input  2  is the access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 i_ULOAD  input  1  selects zero-extension (1) or sign-extension (0) on loads.
REQ-011 o_MEM_RDATA  output  32  is the aligned and extended load data.
REQ-012 o_ACK  output  1  is a one-cycle completion pulse.
REQ-013 o_FAULT  output  1  is valid with o_ACK and flags a rejected request.

Function
REQ-014 A request is i_MEM_RE or i_MEM_WE high; the requester SHALL hold all request inputs stable until o_ACK.
REQ-015 FSM states: IDLE, WACK, RWAIT, RACK, EACK; a request is accepted only in IDLE.
REQ-016 Fault conditions: RE and WE both high, HB=11, half at addr[0]=1, word at addr[1:0]!=0, or address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
REQ-017 On a faulting request: IDLE->EACK; in EACK, o_ACK=1, o_FAULT=1, o_MEM_RDATA=0, and no array write occurs.
REQ-018 On a store: byte lanes SHALL be written at the acceptance edge; IDLE->WACK; in WACK, o_ACK=1 and o_FAULT=0.
REQ-019 Store byte enables: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; data replicated across lanes.
REQ-020 On a load, IDLE->RWAIT->RACK; the array read is synchronous and registered in RWAIT, so o_ACK rises 2 cycles after acceptance.
REQ-021 Load extraction: select the lane by addr[1:0]; bit 7 (byte) or bit 15 (half) is the sign bit; word loads pass through.
REQ-022 WACK, RACK, and EACK SHALL return to IDLE unconditionally; a request still asserted is accepted as new on the following cycle.
REQ-023 Outside ack cycles: o_ACK=0, o_FAULT=0, and o_MEM_RDATA holds its last value.
REQ-024 A load from a word stored in the immediately preceding transaction SHALL return the new data (no bypass needed given the sequencing).
REQ-025 Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after the range check.

Reset
REQ-026 Reset asserted SHALL force IDLE, o_ACK=0, o_FAULT=0, and o_MEM_RDATA=0 immediately, without waiting for a clock.
REQ-027 Reset mid-transaction aborts it without an ack; a store already written at acceptance remains in the array.
REQ-028 Array contents are not reset.

Structure
REQ-029 A shared package SHALL hold the HB size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state encodings.
REQ-030 The data array is a single sub-module, dmem_ram: 4 byte lanes, synchronous read, per-lane write enable.
REQ-031 Lane alignment, extension, and fault decode SHALL be combinational logic in dmem_responder.

Verification
REQ-032 Store word 0xDEADBEEF @0x10, then load word @0x10 -> WACK ack; load ack 2 cycles after acceptance with 0xDEADBEEF, fault 0.
REQ-033 Byte loads @0x11, i_ULOAD=0 then 1 -> 0xFFFFFFBE, then 0x000000BE.
REQ-034 Store half 0x1234 @0x12, then load word @0x10 -> 0x1234BEEF.
REQ-035 Load word @0x11, load half @0x13, and RE+WE together -> each gets o_ACK=1, o_FAULT=1, rdata 0, and the array is unchanged.
REQ-036 Back-to-back requests held high across the ack -> the next request is accepted the cycle after the ack.
REQ-037 Assert i_RSTn low during RWAIT -> outputs go to 0 asynchronously, no ack is issued, and the next request after reset completes normally.
